// File: rtl/soc_system_gpio_pio_ex.sv
// soc_system_gpio_pio_ex: Avalon-MM GPIO slave with per-bit direction, atomic
// set/clear, synchronised inputs, edge capture and a maskable level interrupt.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   address[2:0]        register word address
//   chipselect, write_n slave select and active-low write strobe
//   writedata[31:0]     write data; bits at and above WIDTH ignored
//   readdata[31:0]      combinational read data; bits at and above WIDTH read 0
//   in_port[WIDTH]      asynchronous pin inputs
//   out_port[WIDTH]     pin output values
//   oe_port[WIDTH]      pin output enables (1 = drive)
//   irq                 level interrupt, |(edge_capture & mask)
//
// Register map: 0 DATA, 1 DIR, 2 MASK, 3 EDGE (W1C), 4 OUTSET, 5 OUTCLR,
//               6-7 reserved.
module soc_system_gpio_pio_ex #(
  parameter int unsigned       WIDTH       = 12,
  parameter logic [WIDTH-1:0]  RESET_OUT   = '0,
  parameter logic [WIDTH-1:0]  RESET_DIR   = '0,
  parameter int unsigned       EDGE_TYPE   = 0,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  localparam int unsigned PRIME_MAX = SYNC_STAGES + 1;
  localparam int unsigned PRIME_W   = $clog2(PRIME_MAX + 1);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  logic                              wr;
  logic [WIDTH-1:0]                  wd;
  logic [WIDTH-1:0]                  data_out_q;
  logic [WIDTH-1:0]                  dir_q;
  logic [WIDTH-1:0]                  mask_q;
  logic [WIDTH-1:0]                  edge_cap_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  in_sync;
  logic [WIDTH-1:0]                  in_prev_q;
  logic [PRIME_W-1:0]                prime_q;
  logic                              primed;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;
  logic [WIDTH-1:0]                  edge_sel;
  logic [WIDTH-1:0]                  edge_det;
  logic [WIDTH-1:0]                  edge_clr;
  logic                              unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  // Output and control registers; one address per write so no set/clear conflict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_OUT;
      dir_q      <= RESET_DIR;
      mask_q     <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data_out_q <= wd;
        ADDR_DIR:    dir_q      <= wd;
        ADDR_MASK:   mask_q     <= wd;
        ADDR_OUTSET: data_out_q <= data_out_q | wd;
        ADDR_OUTCLR: data_out_q <= data_out_q & ~wd;
        default: ;
      endcase
    end
  end

  // Input synchroniser chain followed by the previous-value flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      in_prev_q <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], in_port};
      in_prev_q <= in_sync;
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

  // Prime counter holds off edge detection until the chain holds real pin data,
  // so a pin already high at reset release is not seen as a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_q <= '0;
    end else if (!primed) begin
      prime_q <= prime_q + PRIME_W'(1);
    end
  end

  assign primed = (prime_q == PRIME_W'(PRIME_MAX));

  assign rise = in_sync & ~in_prev_q;
  assign fall = ~in_sync & in_prev_q;

  // Edge polarity selection.
  always_comb begin
    edge_sel = rise;
    case (EDGE_TYPE)
      1:       edge_sel = fall;
      2:       edge_sel = rise | fall;
      default: edge_sel = rise;
    endcase
  end

  assign edge_det = primed ? edge_sel : '0;
  assign edge_clr = (wr && (address == ADDR_EDGE)) ? wd : '0;

  // Edge capture: write-1-to-clear, a coincident new edge keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap_q <= '0;
    end else begin
      edge_cap_q <= (edge_cap_q & ~edge_clr) | edge_det;
    end
  end

  // Combinational read mux; reads have no side effects.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = 32'((dir_q & data_out_q) | (~dir_q & in_sync));
      ADDR_DIR:  readdata = 32'(dir_q);
      ADDR_MASK: readdata = 32'(mask_q);
      ADDR_EDGE: readdata = 32'(edge_cap_q);
      default:   readdata = '0;
    endcase
  end

  assign out_port = data_out_q;
  assign oe_port  = dir_q;
  assign irq      = |(edge_cap_q & mask_q);

endmodule

// File: tb/tb_soc_system_gpio_pio_ex.sv
// Self-checking bench for soc_system_gpio_pio_ex: directed scenarios with
// literal expectations plus randomized bus/pin traffic against a delay-line
// reference model, compared on every falling clock edge.
module tb_soc_system_gpio_pio_ex;

  localparam int unsigned W  = 12;
  localparam int unsigned S  = 2;
  localparam int unsigned ET = 0;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port;
  logic [W-1:0]  out_port;
  logic [W-1:0]  oe_port;
  logic          irq;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  soc_system_gpio_pio_ex #(
    .WIDTH(W), .RESET_OUT('0), .RESET_DIR('0), .EDGE_TYPE(ET), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe_port(oe_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: register file plus a history of in_port samples, where
  // hist[k] is the pin value sampled k+1 clock edges ago.
  logic [W-1:0] m_out, m_dir, m_mask, m_cap;
  logic [W-1:0] m_hist [S+1];
  int unsigned  m_edges;

  always @(posedge clk or negedge reset_n) begin : model
    logic [W-1:0] s_v, p_v, det, clr, wdv;
    if (!reset_n) begin
      m_out   <= '0;
      m_dir   <= '0;
      m_mask  <= '0;
      m_cap   <= '0;
      m_edges <= 0;
      for (int i = 0; i <= S; i++) m_hist[i] <= '0;
    end else begin
      wdv = writedata[W-1:0];
      s_v = m_hist[S-1];
      p_v = m_hist[S];
      case (ET)
        1:       det = ~s_v & p_v;
        2:       det = s_v ^ p_v;
        default: det = s_v & ~p_v;
      endcase
      if (m_edges < S + 1) det = '0;
      clr = (chipselect && !write_n && address == 3'd3) ? wdv : '0;
      m_cap <= (m_cap & ~clr) | det;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_out  <= wdv;
          3'd1: m_dir  <= wdv;
          3'd2: m_mask <= wdv;
          3'd4: m_out  <= m_out | wdv;
          3'd5: m_out  <= m_out & ~wdv;
          default: ;
        endcase
      end
      m_hist[0] <= in_port;
      for (int i = 1; i <= S; i++) m_hist[i] <= m_hist[i-1];
      if (m_edges < 1000) m_edges <= m_edges + 1;
    end
  end

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'((m_dir & m_out) | (~m_dir & m_hist[S-1]));
      3'd1:    return 32'(m_dir);
      3'd2:    return 32'(m_mask);
      3'd3:    return 32'(m_cap);
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      chk("model_out_port", 32'(out_port), 32'(m_out));
      chk("model_oe_port",  32'(oe_port),  32'(m_dir));
      chk("model_irq",      32'(irq),      32'(|(m_cap & m_mask)));
      chk("model_readdata", readdata,      m_read(address));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    address = a;
    @(negedge clk);
    chk(name, readdata, exp);
    tick();
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_out_port", 32'(out_port), 32'h0);
    chk("rst_oe_port",  32'(oe_port),  32'h0);
    chk("rst_irq",      32'(irq),      32'h0);
    tick();
    rd(3'd2, 32'h0, "rst_mask");
    rd(3'd3, 32'h0, "rst_edge");

    // DATA / OUTSET / OUTCLR
    wr(3'd0, 32'hABC);
    wr(3'd4, 32'h003);
    wr(3'd5, 32'h800);
    @(negedge clk);
    chk("setclr_out_port", 32'(out_port), 32'h2BF);
    tick();
    wr(3'd1, 32'hFFFF_FFFF);
    rd(3'd0, 32'h2BF, "data_all_out");
    rd(3'd1, 32'hFFF, "dir_upper_zero");
    rd(3'd4, 32'h0, "outset_reads0");
    rd(3'd6, 32'h0, "reserved_reads0");

    // Mixed direction readback
    wr(3'd1, 32'h0F0);
    wr(3'd0, 32'hFFF);
    in_port = 12'h00A;
    repeat (S + 1) tick();
    rd(3'd0, 32'h0FA, "data_mixed");

    // Edge capture latency and irq
    in_port = '0;
    repeat (5) tick();
    wr(3'd3, 32'hFFF);
    wr(3'd2, 32'h001);
    address = 3'd3;
    in_port = 12'h001;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("irq_latency_%0d", k), 32'(irq), (k == 3) ? 32'h1 : 32'h0);
      chk($sformatf("edge_latency_%0d", k), readdata, (k == 3) ? 32'h1 : 32'h0);
    end
    tick();
    wr(3'd3, 32'h001);
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'h0);
    tick();

    // Coincident edge and clear: set wins
    in_port = '0;
    repeat (4) tick();
    in_port = 12'h001;
    repeat (4) tick();
    @(negedge clk);
    chk("irq_before_collide", 32'(irq), 32'h1);
    tick();
    in_port = '0;
    repeat (4) tick();
    in_port = 12'h001;
    tick();
    tick();
    wr(3'd3, 32'h001);
    @(negedge clk);
    chk("collide_irq", 32'(irq), 32'h1);
    chk("collide_edge", readdata, 32'h1);
    tick();

    // Reset mid-write, pins high through release
    in_port    = 12'hFFF;
    wr(3'd1, 32'h00F);
    address    = 3'd0;
    writedata  = 32'h555;
    chipselect = 1'b1;
    write_n    = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_port", 32'(out_port), 32'h0);
    chk("midrst_oe_port",  32'(oe_port),  32'h0);
    chk("midrst_irq",      32'(irq),      32'h0);
    chk("midrst_readdata", readdata,      32'h0);
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    rd(3'd3, 32'h0, "no_spurious_edge");
    rd(3'd0, 32'hFFF, "data_pins_high");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 4) in_port = W'($urandom);
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      if (i == 1500) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rand_rst_out_port", 32'(out_port), 32'h0);
        chk("rand_rst_irq",      32'(irq),      32'h0);
        tick();
        reset_n = 1'b1;
      end
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
